// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write/read controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH   = 4;
  localparam int FIFO_AFULL_THRESH = 12;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // Pointers carry one extra wrap bit over the memory address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_cmp.sv
// Pointer distance compare: a - b modulo 2**P, with level, threshold and
// out-of-range detection. Reused by the read side for empty/almost-empty.
module fifo_ptr_cmp
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int THRESH     = FIFO_AFULL_THRESH
) (
  input  logic [ADDR_WIDTH:0] ptr_a_i,
  input  logic [ADDR_WIDTH:0] ptr_b_i,
  output logic [ADDR_WIDTH:0] diff_o,
  output logic                full_o,
  output logic                thresh_o,
  output logic                err_o
);

  localparam int P = ptr_width(ADDR_WIDTH);
  localparam logic [P-1:0] DEPTH_P  = P'(2**ADDR_WIDTH);
  localparam logic [P-1:0] THRESH_P = P'(THRESH);

  assign diff_o   = ptr_a_i - ptr_b_i;
  assign full_o   = (diff_o == DEPTH_P);
  assign thresh_o = (diff_o >= THRESH_P);
  assign err_o    = (diff_o > DEPTH_P);

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: accepts writes, owns the binary
// write pointer and derives full/almost-full/occupancy from the synced read ptr.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_THRESH = FIFO_AFULL_THRESH,
  parameter int INIT_CYCLES  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_req_i,
  output logic                  wr_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [ADDR_WIDTH:0]   wr_ptr_o,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_count_o,
  input  logic                  ovf_clr_i,
  output logic                  overflow_o,
  output logic                  ptr_err_o
);

  localparam int P  = ptr_width(ADDR_WIDTH);
  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [P-1:0] DEPTH_P = P'(2**ADDR_WIDTH);

  ctrl_state_e   state_q;
  logic [CW-1:0] init_cnt_q;
  logic [P-1:0]  wr_ptr_q, wr_ptr_d, count_q, diff;
  logic          full_q, afull_q, ovf_q, perr_q;
  logic          accept, run, cmp_full, cmp_afull, cmp_err;

  assign run         = (state_q == ST_RUN);
  assign wr_ready_o  = run && !full_q;
  assign accept      = wr_req_i && wr_ready_o;
  assign mem_we_o    = accept;
  assign mem_waddr_o = wr_ptr_q[ADDR_WIDTH-1:0];
  assign wr_ptr_d    = wr_ptr_q + P'(accept);

  // Flags look at the post-write pointer so a write can never land at DEPTH.
  fifo_ptr_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .THRESH     (AFULL_THRESH)
  ) u_cmp (
    .ptr_a_i  (wr_ptr_d),
    .ptr_b_i  (rd_ptr_sync_i),
    .diff_o   (diff),
    .full_o   (cmp_full),
    .thresh_o (cmp_afull),
    .err_o    (cmp_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wr_ptr_q   <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      if (!run) begin
        if (init_cnt_q == CW'(INIT_CYCLES - 1)) state_q <= ST_RUN;
        else                                    init_cnt_q <= init_cnt_q + CW'(1);
      end else begin
        wr_ptr_q <= wr_ptr_d;
        // Corrupt distance: report full so the producer is blocked.
        if (cmp_err) begin
          full_q  <= 1'b1;
          afull_q <= 1'b1;
          count_q <= DEPTH_P;
        end else begin
          full_q  <= cmp_full;
          afull_q <= cmp_afull;
          count_q <= diff;
        end
      end
      ovf_q  <= (run && wr_req_i && full_q) || (ovf_q && !ovf_clr_i);
      perr_q <= (run && cmp_err) || (perr_q && !ovf_clr_i);
    end
  end

  assign wr_ptr_o      = wr_ptr_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign wr_count_o    = count_q;
  assign overflow_o    = ovf_q;
  assign ptr_err_o     = perr_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl (DEPTH=4, AFULL_THRESH=3, INIT_CYCLES=3) against an
// integer occupancy model.
module tb_fifo_wr_ctrl;

  localparam int AW = 2, TH = 3, IC = 3, DEPTH = 4, PMOD = 8;

  logic       clk = 1'b0;
  logic       rst, wr_req, ovf_clr;
  logic [2:0] rd_ptr_sync;
  logic       wr_ready, mem_we, full, almost_full, overflow, ptr_err;
  logic [1:0] mem_waddr;
  logic [2:0] wr_ptr, wr_count;

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(TH), .INIT_CYCLES(IC)) dut (
    .clk_i(clk), .rst_i(rst), .wr_req_i(wr_req), .wr_ready_o(wr_ready),
    .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .wr_ptr_o(wr_ptr),
    .rd_ptr_sync_i(rd_ptr_sync), .full_o(full), .almost_full_o(almost_full),
    .wr_count_o(wr_count), .ovf_clr_i(ovf_clr), .overflow_o(overflow),
    .ptr_err_o(ptr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Model: cycles spent in INIT, write count modulo 2*DEPTH, flag values.
  int m_icnt, m_wptr, m_cnt;
  bit m_run, m_full, m_af, m_ovf, m_perr;

  function automatic logic [13:0] obs();
    return {wr_ready, mem_we, mem_waddr, wr_ptr, full, almost_full, wr_count, overflow, ptr_err};
  endfunction

  function automatic logic [13:0] expv();
    bit rdy = m_run && !m_full;
    bit we  = rdy && wr_req;
    return {rdy, we, 2'(m_wptr % DEPTH), 3'(m_wptr), m_full, m_af, 3'(m_cnt), m_ovf, m_perr};
  endfunction

  task automatic drive(input bit r, input bit q, input int rd, input bit c);
    rst = r; wr_req = q; rd_ptr_sync = 3'(rd); ovf_clr = c;
    #1;
  endtask

  task automatic advance();
    int occ, nptr;
    bit acc, ovset, bad;
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_icnt = 0; m_wptr = 0; m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0; m_perr = 0;
    end else begin
      acc   = wr_req && m_run && !m_full;
      ovset = m_run && wr_req && m_full;
      bad   = 0;
      if (!m_run) begin
        m_icnt++;
        if (m_icnt >= IC) m_run = 1;
      end else begin
        nptr = (m_wptr + int'(acc)) % PMOD;
        occ  = (nptr - int'(rd_ptr_sync) + PMOD) % PMOD;
        bad  = occ > DEPTH;
        if (bad) begin
          m_full = 1; m_af = 1; m_cnt = DEPTH;
        end else begin
          m_full = (occ == DEPTH); m_af = (occ >= TH); m_cnt = occ;
        end
        m_wptr = nptr;
      end
      m_ovf  = ovset || (m_ovf && !ovf_clr);
      m_perr = bad || (m_perr && !ovf_clr);
    end
    @(negedge clk);
  endtask

  task automatic reset_init();
    drive(1, 0, 0, 0); advance();
    for (int i = 0; i < IC; i++) begin drive(0, 0, 0, 0); advance(); end
  endtask

  task automatic test_reset();
    int first = -1;
    drive(1, 0, 0, 0); advance();
    drive(0, 0, 0, 0);
    n_vec++;
    if (obs() !== 14'h0) begin n_err++; $display("FAIL reset_state got %h want %h", obs(), 14'h0); end
    for (int i = 0; i < 8 && first < 0; i++) begin
      drive(0, 1, 0, 0);
      n_vec++;
      if (obs() !== expv()) begin n_err++; $display("FAIL init_cyc%0d got %h want %h", i, obs(), expv()); end
      if (mem_we === 1'b1) begin
        first = i;
        n_vec++;
        if (mem_waddr !== 2'd0) begin n_err++; $display("FAIL first_waddr got %0d want 0", mem_waddr); end
      end
      advance();
    end
    n_vec++;
    if (first != IC) begin n_err++; $display("FAIL init_len got %0d want %0d", first, IC); end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL init_ovf got %b want 0", overflow); end
  endtask

  task automatic test_fill();
    logic [1:0] addrs[$];
    reset_init();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0);
      n_vec++;
      if (obs() !== expv()) begin n_err++; $display("FAIL fill_cyc%0d got %h want %h", k, obs(), expv()); end
      if (k == 3) begin
        n_vec++;
        if ({almost_full, full} !== 2'b10) begin n_err++; $display("FAIL fill_afull got %b want 10", {almost_full, full}); end
      end
      if (mem_we === 1'b1) addrs.push_back(mem_waddr);
      advance();
    end
    n_vec++;
    if (addrs.size() != 4 || addrs[0] !== 2'd0 || addrs[1] !== 2'd1 || addrs[2] !== 2'd2 || addrs[3] !== 2'd3) begin
      n_err++; $display("FAIL fill_addrs got %0d writes want 0,1,2,3", addrs.size());
    end
    n_vec++;
    if ({wr_ptr, full, overflow, wr_ready} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL fill_end got ptr=%0d full=%b ovf=%b rdy=%b want 4 1 1 0", wr_ptr, full, overflow, wr_ready);
    end
  endtask

  task automatic test_drain();
    drive(0, 0, 1, 0);
    n_vec++;
    if (obs() !== expv()) begin n_err++; $display("FAIL drain_pre got %h want %h", obs(), expv()); end
    advance();
    drive(0, 1, 1, 0);
    n_vec++;
    if ({full, wr_count} !== {1'b0, 3'd3}) begin n_err++; $display("FAIL drain_rel got full=%b cnt=%0d want 0 3", full, wr_count); end
    n_vec++;
    if ({mem_we, mem_waddr} !== {1'b1, 2'd0}) begin n_err++; $display("FAIL drain_wr got we=%b a=%0d want 1 0", mem_we, mem_waddr); end
    advance();
    n_vec++;
    if (wr_ptr !== 3'd5) begin n_err++; $display("FAIL drain_ptr got %0d want 5", wr_ptr); end
  endtask

  task automatic test_wrap();
    int stim[4][2] = '{'{0, 5}, '{1, 5}, '{1, 5}, '{1, 6}};
    for (int k = 0; k < 4; k++) begin
      drive(0, stim[k][0][0], stim[k][1], 0);
      n_vec++;
      if (obs() !== expv()) begin n_err++; $display("FAIL wrap_cyc%0d got %h want %h", k, obs(), expv()); end
      advance();
    end
    n_vec++;
    if ({wr_ptr, wr_count, ptr_err} !== {3'd0, 3'd2, 1'b0}) begin
      n_err++; $display("FAIL wrap_end got ptr=%0d cnt=%0d perr=%b want 0 2 0", wr_ptr, wr_count, ptr_err);
    end
  endtask

  task automatic test_corrupt();
    reset_init();
    for (int k = 0; k < 3; k++) begin
      drive(0, k < 2, (k < 2) ? 0 : 5, 0);
      n_vec++;
      if (obs() !== expv()) begin n_err++; $display("FAIL corrupt_cyc%0d got %h want %h", k, obs(), expv()); end
      advance();
    end
    drive(0, 0, 5, 0);
    n_vec++;
    if ({ptr_err, full, wr_count, wr_ready} !== {1'b1, 1'b1, 3'd4, 1'b0}) begin
      n_err++; $display("FAIL corrupt_end got perr=%b full=%b cnt=%0d rdy=%b want 1 1 4 0", ptr_err, full, wr_count, wr_ready);
    end
  endtask

  task automatic test_sticky();
    reset_init();
    for (int k = 0; k < 5; k++) begin drive(0, 1, 0, 0); advance(); end
    n_vec++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL sticky_set got %b want 1", overflow); end
    drive(0, 0, 0, 1); advance();
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL sticky_clr got %b want 0", overflow); end
    drive(0, 1, 0, 1); advance();
    n_vec++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL sticky_setwins got %b want 1", overflow); end
    n_vec++;
    if (obs() !== expv()) begin n_err++; $display("FAIL sticky_state got %h want %h", obs(), expv()); end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      k = ($urandom_range(0, 39) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, DEPTH));
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
            (m_wptr - k + PMOD) % PMOD, $urandom_range(0, 7) == 0);
      n_vec++;
      if (obs() !== expv()) begin n_err++; $display("FAIL rand_cyc%0d got %h want %h", i, obs(), expv()); end
      advance();
    end
  endtask

  initial begin
    drive(1, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_corrupt();
    test_sticky();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the asynchronous FIFO, living entirely in the write clock domain. It accepts write requests and drives the dual-port memory write enable and address. It keeps the binary write pointer, which feeds the write-to-read synchronizer. It computes full, almost-full and occupancy from the synchronized read pointer returned from the read domain, and flags protocol errors.

Parameters:
ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH; pointer width P = ADDR_WIDTH+1
AFULL_THRESH, 12, almost_full asserts when occupancy >= this value (1..DEPTH)
INIT_CYCLES, 3, cycles held in INIT after reset so synchronized pointers settle (>=1)

Ports:
clk  in  1  write-domain clock
rst  in  1  synchronous active-high reset
wr_req  in  1  producer requests a write this cycle
wr_ready  out  1  controller can accept; write occurs when wr_req && wr_ready
mem_we  out  1  memory write enable
mem_waddr  out  ADDR_WIDTH  memory write address
wr_ptr  out  P  binary write pointer (registered), to synchronizer data_in
rd_ptr_sync  in  P  binary read pointer from synchronizer data_out
full  out  1  registered full flag
almost_full  out  1  registered almost-full flag
wr_count  out  P  registered occupancy estimate, 0..DEPTH
ovf_clr  in  1  clears sticky error flags
overflow  out  1  sticky: wr_req seen while RUN and full
ptr_err  out  1  sticky: observed occupancy > DEPTH (corrupt sync path)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=INIT, init counter=0, wr_ptr=0, full=0, almost_full=0, wr_count=0, overflow=0, ptr_err=0.
- Outputs derived from reset state: wr_ready=0, mem_we=0, mem_waddr=0.
- States:
  - INIT: count INIT_CYCLES cycles, then go to RUN. wr_ready=0 throughout. Requests are ignored and do not set overflow.
  - RUN: steady state. No exit except rst.
- Reset asserted mid-operation returns to INIT next edge, wr_ptr=0. The read domain must be reset together; this is a system-level rule.
- wr_ready = (state==RUN) && !full. This is combinational from registers; it has no path from wr_req.
- accept = wr_req && wr_ready.
- mem_we = accept (combinational, same cycle). mem_waddr = wr_ptr[ADDR_WIDTH-1:0]. Data is written at the edge ending the accept cycle.
- wr_ptr_next = wr_ptr + accept, modulo 2**P. It wraps from 2**P-1 to 0 with no special case.
- diff = (wr_ptr_next - rd_ptr_sync) mod 2**P, unsigned P bits.
- Each edge in RUN:
  - full <= (diff == DEPTH)
  - almost_full <= (diff >= AFULL_THRESH)
  - wr_count <= diff
- If diff > DEPTH:
  - set ptr_err.
  - force full=1, almost_full=1, wr_count=DEPTH (fail safe, block writes).
- Flags are pessimistic: rd_ptr_sync lags the true read pointer, so full may persist extra cycles after reads. This is allowed. Missing full is never allowed.
- The full flag uses wr_ptr_next, so no write can ever occur at occupancy DEPTH. Latency from accept to updated flags: 1 cycle.
- Latency from an rd_ptr_sync change to full deassert: 1 cycle.
- overflow sets when state==RUN && wr_req && full.
- Sticky flags (overflow, ptr_err) clear on ovf_clr. If set and clear occur in the same cycle, set wins.
- rd_ptr_sync is sampled only through the registered flag logic. It must be stable binary, which the gray synchronizer guarantees.

Decomposition:
- Shared package fifo_pkg holds:
  - ptr width function (ADDR_WIDTH+1)
  - state encoding constants INIT=1'b0, RUN=1'b1
  - default DEPTH and AFULL_THRESH constants, reused by the future fifo_rd_ctrl
- One natural sub-module: fifo_ptr_cmp, a combinational diff/full/almost_full/error computation. It is shared later with the read-side controller (empty/almost_empty).

Test Plan:
All scenarios use ADDR_WIDTH=2 (DEPTH=4), AFULL_THRESH=3, INIT_CYCLES=3.
- Reset/INIT: rst 1 cycle, then wr_req=1 constantly, rd_ptr_sync=0 -> wr_ready=0 and mem_we=0 for exactly 3 cycles, first accept on 4th cycle with mem_waddr=0, overflow stays 0.
- Fill: 4 back-to-back accepts with rd_ptr_sync=0 -> mem_waddr 0,1,2,3; almost_full=1 after 3rd accept, full=1 after 4th; wr_ptr=4; 5th request not accepted, overflow=1 next cycle.
- Drain release: from full, rd_ptr_sync 0->1 -> full=0, wr_count=3 one cycle later; next accept writes mem_waddr=0, wr_ptr=5.
- Wrap: drive wr_ptr to 7 with rd_ptr_sync=6, accept one -> wr_ptr=0, wr_count=2, no ptr_err.
- Corrupt sync: with wr_ptr=2, force rd_ptr_sync=5 (diff=5>4) -> ptr_err=1, full=1, wr_count=4, wr_ready=0.
- Sticky clear: overflow=1, assert ovf_clr with no wr_req -> overflow=0. Assert ovf_clr and wr_req while full in the same cycle -> overflow stays 1.
